// File: rtl/pcie_pkg.sv
// Shared definitions for the four-VC pop scheduler: state encodings,
// channel count, readout selector values and a small one-hot helper.
package pcie_pkg;

    localparam int unsigned NUM_VC  = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned PTR_W   = 2;

    localparam logic [IDX_W-1:0] IDX_TOTAL = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Index of the set bit in a one-hot channel vector (0 when empty).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_VC-1:0] oh);
        logic [PTR_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (oh[i]) begin
                res = PTR_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin arbiter: first requester at or after
// the pointer, wrapping modulo four, receives a one-hot grant.
module rr_arbiter4
    import pcie_pkg::*;
(
    input  logic [NUM_VC-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_VC-1:0] gnt_c_o
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt_c_o = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            // 2-bit addition wraps the search naturally at NUM_VC
            pos = ptr_i + PTR_W'(k);
            if (!found && req_i[pos]) begin
                gnt_c_o[pos] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Control block for the four-VC FIFO datapath: phase FSM, threshold latch,
// urgency-aware round-robin pop arbitration, backpressure and pop counters.
module vc_pop_scheduler
    import pcie_pkg::*;
#(
    parameter int unsigned UMBRALES_L_H = 8,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRALES_L_H-1:0] umbral_L_in,
    input  logic [UMBRALES_L_H-1:0] umbral_H_in,
    input  logic [NUM_VC-1:0]       vc_empty,
    input  logic [NUM_VC-1:0]       vc_almost_full,
    input  logic [NUM_VC-1:0]       out_ready,
    input  logic [NUM_VC-1:0]       fifo_error,
    input  logic                    req,
    input  logic [IDX_W-1:0]        idx,
    output logic [UMBRALES_L_H-1:0] umbral_L,
    output logic [UMBRALES_L_H-1:0] umbral_H,
    output logic [NUM_VC-1:0]       pop,
    output logic                    pause,
    output logic                    idle,
    output logic                    error_out,
    output logic [STATE_W-1:0]      state,
    output logic [CNT_W-1:0]        cnt_out,
    output logic                    cnt_valid
);

    state_e                  state_q, state_d;
    logic [UMBRALES_L_H-1:0] umbral_l_q, umbral_l_d;
    logic [UMBRALES_L_H-1:0] umbral_h_q, umbral_h_d;
    logic [NUM_VC-1:0]       pop_q, pop_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    pause_q, pause_d;
    logic                    idle_q, idle_d;
    logic                    error_q, error_d;

    logic [CNT_W-1:0]        cnt_q [NUM_VC];
    logic [CNT_W-1:0]        total_q;
    logic [CNT_W-1:0]        cnt_out_q;
    logic                    cnt_valid_q;
    logic [CNT_W-1:0]        rd_val_c;

    logic [NUM_VC-1:0]       elig_c;
    logic [NUM_VC-1:0]       urgent_c;
    logic [NUM_VC-1:0]       arb_req_c;
    logic [NUM_VC-1:0]       gnt_c;

    // The last-cycle pop term keeps a 1-entry FIFO from being popped twice
    assign elig_c    = ~vc_empty & out_ready & ~pop_q;
    assign urgent_c  = elig_c & vc_almost_full;
    assign arb_req_c = (|urgent_c) ? urgent_c : elig_c;

    rr_arbiter4 u_arb (
        .req_i   (arb_req_c),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (gnt_c)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_RESET;
            umbral_l_q <= '0;
            umbral_h_q <= '0;
            pop_q      <= '0;
            rr_ptr_q   <= '0;
            pause_q    <= 1'b1;
            idle_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            umbral_l_q <= umbral_l_d;
            umbral_h_q <= umbral_h_d;
            pop_q      <= pop_d;
            rr_ptr_q   <= rr_ptr_d;
            pause_q    <= pause_d;
            idle_q     <= idle_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        umbral_l_d = umbral_l_q;
        umbral_h_d = umbral_h_q;
        pop_d      = '0;
        rr_ptr_d   = rr_ptr_q;
        pause_d    = 1'b1;
        idle_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) begin
                    state_d = (umbral_l_q >= umbral_h_q) ? ST_ERROR : ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (|fifo_error) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if ((state_q == ST_IDLE) && !(&vc_empty)) begin
                    state_d = ST_ACTIVE;
                end else if ((state_q == ST_ACTIVE) && (&vc_empty)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        if (state_q == ST_INIT) begin
            umbral_l_d = umbral_L_in;
            umbral_h_d = umbral_H_in;
        end

        // Grants only while staying in ACTIVE, so leaving it drops pop next cycle
        if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && (|gnt_c)) begin
            pop_d    = gnt_c;
            rr_ptr_d = onehot_to_idx(gnt_c) + PTR_W'(1);
        end

        if ((state_d == ST_IDLE) || (state_d == ST_ACTIVE)) begin
            pause_d = |vc_almost_full;
        end
        idle_d  = (state_d == ST_IDLE) && (&vc_empty);
        error_d = (state_d == ST_ERROR);
    end

    // Pop counters: cleared in INIT; a pop already on the bus always counts
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= '0;
            end
            total_q <= '0;
        end else if (state_q == ST_INIT) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= '0;
            end
            total_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                if (pop_q[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            if (|pop_q) begin
                total_q <= total_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_val_c = '0;
        if (idx < IDX_W'(NUM_VC)) begin
            rd_val_c = cnt_q[idx[PTR_W-1:0]];
        end else if (idx == IDX_TOTAL) begin
            rd_val_c = total_q;
        end
    end

    // Readout samples pre-increment counter values
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            cnt_valid_q <= 1'b0;
            if (req && (state_q != ST_RESET)) begin
                cnt_out_q   <= rd_val_c;
                cnt_valid_q <= 1'b1;
            end
        end
    end

    assign umbral_L  = umbral_l_q;
    assign umbral_H  = umbral_h_q;
    assign pop       = pop_q;
    assign pause     = pause_q;
    assign idle      = idle_q;
    assign error_out = error_q;
    assign state     = state_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;

endmodule
